// File: rtl/adding_fetch_stage.sv
// Fetch stage feeding the pipelined adding machine: walks a word index over a
// combinational ROM for a programmed run length and buffers words in a small FIFO.
module adding_fetch_stage #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [ADDR_W-1:0]        base,
   input  logic [LEN_W-1:0]         length,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_data,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic                     done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   index_q, index_d;
   logic [LEN_W-1:0]    remaining_q, remaining_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]   last_q, last_d;
   logic [DATA_W-1:0]   storage_q [DEPTH];
   logic                push;
   logic                pop;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      index_d     = index_q;
      remaining_d = remaining_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      last_d      = last_q;

      // Push eligibility uses the pre-pop count: a full FIFO never takes a word,
      // even when the head is leaving in the same cycle.
      push = (state_q == S_FETCH) && (count_q != CNT_W'(DEPTH));
      pop  = (count_q != '0) && out_ready;

      if (push) begin
         wr_ptr_d    = wr_ptr_q + PTR_W'(1);
         index_d     = index_q + ADDR_W'(1);
         remaining_d = remaining_q - LEN_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         last_d   = storage_q[rd_ptr_q];
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               index_d     = base;
               remaining_d = length;
               state_d     = (length == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (push && (remaining_q == LEN_W'(1))) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (count_d == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort cancels the whole cycle's work but keeps the index where it stopped.
      if (abort) begin
         push        = 1'b0;
         state_d     = S_IDLE;
         index_d     = index_q;
         remaining_d = remaining_q;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         remaining_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         last_q      <= '0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         remaining_q <= remaining_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         last_q      <= last_d;
      end
   end

   // NOTE: the storage array has no reset; an entry is only read once the count says it was written.
   always_ff @(posedge clk) begin
      if (push) begin
         storage_q[wr_ptr_q] <= mem_data;
      end
   end

   assign mem_addr   = index_q;
   assign out_valid  = (count_q != '0);
   assign out_data   = out_valid ? storage_q[rd_ptr_q] : last_q;
   assign fifo_count = count_q;
   assign busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_adding_fetch_stage.sv
// Directed bench for adding_fetch_stage: ROM[i] = i+1, checks sampled 1 time unit after each edge.
module tb_adding_fetch_stage;

   logic          clk;
   logic          reset;
   logic          start;
   logic          abort;
   logic [29:0]   base;
   logic [15:0]   length;
   logic [29:0]   mem_addr;
   logic [31:0]   mem_data;
   logic [31:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    fifo_count;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_pass   = 0;
   int sum      = 0;

   adding_fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .base       (base),
      .length     (length),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_count (fifo_count),
      .busy       (busy),
      .done       (done)
   );

   assign mem_data = {2'b00, mem_addr} + 32'd1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      base = '0; length = '0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_count", fifo_count, 0);
      check("rst_data", out_data, 0);
      check("rst_addr", mem_addr, 0);
      reset = 1'b0;
      tick();

      // 1: five words streamed with out_ready high
      base = 30'd0; length = 16'd5; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_busy", busy, 1);
      check("t1_nvalid", out_valid, 0);
      check("t1_addr0", mem_addr, 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("t1_valid", out_valid, 1);
         check("t1_data", out_data, i);
         sum += int'(out_data);
      end
      tick();
      check("t1_done", done, 1);
      check("t1_empty", out_valid, 0);
      check("t1_busy_off", busy, 0);
      check("t1_sum", sum, 15);
      tick();
      check("t1_done_once", done, 0);

      // 2: back-pressure until the FIFO is full
      base = 30'd0; length = 16'd6; out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("t2_full", fifo_count, 4);
      check("t2_addr", mem_addr, 4);
      check("t2_head", out_data, 1);
      tick();
      check("t2_stall_addr", mem_addr, 4);
      check("t2_stall_count", fifo_count, 4);
      check("t2_stall_data", out_data, 1);
      out_ready = 1'b1;
      for (int i = 2; i <= 6; i++) begin
         tick();
         check("t2_data", out_data, i);
      end
      tick();
      check("t2_done", done, 1);
      check("t2_empty", out_valid, 0);
      tick();

      // 3: zero-length run
      base = 30'd7; length = 16'd0; start = 1'b1;
      tick();
      start = 1'b0;
      check("t3_done", done, 1);
      check("t3_busy", busy, 0);
      check("t3_valid", out_valid, 0);
      tick();
      check("t3_done_off", done, 0);
      check("t3_busy2", busy, 0);
      check("t3_valid2", out_valid, 0);

      // 4: index wraps at the top of the word space
      base = 30'h3FFF_FFFE; length = 16'd3; start = 1'b1;
      tick();
      start = 1'b0;
      check("t4_addr0", mem_addr, 30'h3FFF_FFFE);
      tick();
      check("t4_addr1", mem_addr, 30'h3FFF_FFFF);
      check("t4_data0", out_data, 32'h3FFF_FFFF);
      tick();
      check("t4_addr2", mem_addr, 0);
      check("t4_data1", out_data, 32'h4000_0000);
      tick();
      check("t4_data2", out_data, 1);
      tick();
      check("t4_done", done, 1);
      tick();

      // 5: abort with two words buffered, then a clean restart
      base = 30'd0; length = 16'd8; out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("t5_count2", fifo_count, 2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_valid", out_valid, 0);
      check("t5_count", fifo_count, 0);
      check("t5_busy", busy, 0);
      check("t5_nodone", done, 0);
      check("t5_addr_kept", mem_addr, 2);
      tick();
      check("t5_nodone2", done, 0);
      check("t5_idle", busy, 0);
      base = 30'd10; length = 16'd2; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("t5_rbusy", busy, 1);
      tick();
      check("t5_rdata0", out_data, 11);
      tick();
      check("t5_rdata1", out_data, 12);
      tick();
      check("t5_rdone", done, 1);
      tick();

      // 6a: start during FETCH does not reload the run
      base = 30'd0; length = 16'd4; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("t6_data1", out_data, 1);
      base = 30'd50; length = 16'd20; start = 1'b1;
      tick();
      start = 1'b0;
      check("t6_data2", out_data, 2);
      tick();
      check("t6_data3", out_data, 3);
      tick();
      check("t6_data4", out_data, 4);
      tick();
      check("t6_done", done, 1);
      tick();

      // 6b: reset mid-FETCH, with start held, returns everything to reset values
      base = 30'd0; length = 16'd6; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("t6_pre_busy", busy, 1);
      reset = 1'b1; start = 1'b1;
      tick();
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_count", fifo_count, 0);
      check("t6_rst_data", out_data, 0);
      check("t6_rst_addr", mem_addr, 0);
      reset = 1'b0; start = 1'b0;
      tick();
      check("t6_post_busy", busy, 0);
      check("t6_post_valid", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
